// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined add/subtract, one SEG-bit carry-lookahead segment per stage.
// Optional CLA_PIPE_SAT_EN: saturate the result to the signed limits on overflow.
module cla_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / 4;

  // SEG-bit add from 4-bit lookahead groups; returns {carry_out, sum}
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] s;
    logic [NGRP:0]  gc;
    logic [3:0]     g4, p4, c4;
    logic           gg, gp;
    s     = '0;
    gc    = '0;
    gc[0] = ci;
    for (int j = 0; j < NGRP; j++) begin
      g4    = x[4*j +: 4] & y[4*j +: 4];
      p4    = x[4*j +: 4] ^ y[4*j +: 4];
      c4[0] = gc[j];
      c4[1] = g4[0] | (p4[0] & gc[j]);
      c4[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & gc[j]);
      c4[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) | (p4[2] & p4[1] & p4[0] & gc[j]);
      gg    = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) | (p4[3] & p4[2] & p4[1] & g4[0]);
      gp    = &p4;
      gc[j+1]       = gg | (gp & gc[j]);
      s[4*j +: 4]   = p4 ^ c4;
    end
    return {gc[NGRP], s};
  endfunction

  logic [WIDTH-1:0]  a_r    [STAGES];
  logic [WIDTH-1:0]  b_r    [STAGES];
  logic [WIDTH-1:0]  s_r    [STAGES];
  logic [WIDTH-1:0]  a_src  [STAGES];
  logic [WIDTH-1:0]  b_src  [STAGES];
  logic [WIDTH-1:0]  s_base [STAGES];
  logic [WIDTH-1:0]  s_nxt  [STAGES];
  logic [STAGES-1:0] c_r, v_r, c_src, c_nxt, v_src;
  logic [WIDTH-1:0]  raw_sum, fin_sum;
  logic              a_msb, b_msb, ovfl_nxt;
  logic              ovfl_r, zero_r, neg_r;
  logic              adv;

  assign adv      = ~(v_r[STAGES-1] & ~out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG:0] seg_res;
    if (k == 0) begin : g_first
      assign a_src[k]  = a;
      assign b_src[k]  = sub ? ~b : b;
      assign s_base[k] = '0;
      assign c_src[k]  = sub;
      assign v_src[k]  = in_valid;
    end else begin : g_next
      assign a_src[k]  = a_r[k-1];
      assign b_src[k]  = b_r[k-1];
      assign s_base[k] = s_r[k-1];
      assign c_src[k]  = c_r[k-1];
      assign v_src[k]  = v_r[k-1];
    end
    assign seg_res  = cla_seg(a_src[k][k*SEG +: SEG], b_src[k][k*SEG +: SEG], c_src[k]);
    assign c_nxt[k] = seg_res[SEG];
    // bits above the processed segments are always zero in the partial sum
    assign s_nxt[k] = s_base[k] | (WIDTH'(seg_res[SEG-1:0]) << (k*SEG));
  end

  assign raw_sum  = s_nxt[STAGES-1];
  assign a_msb    = a_src[STAGES-1][WIDTH-1];
  assign b_msb    = b_src[STAGES-1][WIDTH-1];
  assign ovfl_nxt = (~a_msb & ~b_msb & raw_sum[WIDTH-1]) | (a_msb & b_msb & ~raw_sum[WIDTH-1]);

`ifdef CLA_PIPE_SAT_EN
  // Clamp to the signed limit on the side of operand A
  always_comb begin
    fin_sum = raw_sum;
    if (ovfl_nxt) begin
      fin_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      fin_sum = raw_sum;
    end
  end
`else
  assign fin_sum = raw_sum;
`endif

  // Stage valids: flush empties the pipe, otherwise shift when not stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= '0;
    end else if (flush) begin
      v_r <= '0;
    end else if (adv) begin
      v_r <= v_src;
    end
  end

  // Stage data, carries and final flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
      c_r    <= '0;
      ovfl_r <= 1'b0;
      zero_r <= 1'b0;
      neg_r  <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        a_r[k] <= a_src[k];
        b_r[k] <= b_src[k];
        s_r[k] <= s_nxt[k];
      end
      a_r[STAGES-1] <= a_src[STAGES-1];
      b_r[STAGES-1] <= b_src[STAGES-1];
      s_r[STAGES-1] <= fin_sum;
      c_r    <= c_nxt;
      ovfl_r <= ovfl_nxt;
      zero_r <= (fin_sum == '0);
      neg_r  <= fin_sum[WIDTH-1];
    end
  end

  assign out_valid = v_r[STAGES-1];
  assign sum       = s_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
  assign ovfl      = ovfl_r;
  assign zero      = zero_r;
  assign neg       = neg_r;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed, table-driven bench for cla_pipe_addsub (WIDTH=16, STAGES=4).
module tb_cla_pipe_addsub;

  localparam int W = 16;
`ifdef CLA_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovfl;
    logic         e_zero;
    logic         e_neg;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic sub = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] sum;
  logic cout, ovfl, zero, neg;

  int checks = 0;
  int errors = 0;

  cla_pipe_addsub #(.WIDTH(W), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovfl(ovfl), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: latency and all result fields
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    out_ready = 1'b1;
    chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = v.a; b = v.b; sub = v.sub;
    next_cycle();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      next_cycle();
      lat++;
    end
    chk({name, "_lat"}, lat, 32'd4);
    chk({name, "_res"}, {12'd0, sum, cout, ovfl, zero, neg},
        {12'd0, v.e_sum, v.e_cout, v.e_ovfl, v.e_zero, v.e_neg});
    next_cycle();
  endtask

  // Launch three back-to-back ops and leave them in flight
  task automatic launch3();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h1111 * W'(i + 1); b = 16'h0101; sub = 1'b0;
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  vec_t vecs[10];
  vec_t post;
  logic [W-1:0] exp_q[8];
  logic [W-1:0] held;
  logic was_stalled;
  int seen, idx_in, idx_out, cyc;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0, !SAT};
    vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0, SAT};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h0FF0, 16'h00F0, 1'b0, 16'h10E0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, !SAT, SAT};
    vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{16'hA5A5, 16'h5A5A, 1'b1, SAT ? 16'h8000 : 16'h4B4B, 1'b1, 1'b1, 1'b0, SAT};
    post    = '{16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_outs", {25'd0, out_valid, cout, ovfl, zero, neg, 2'b00}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: 8 streaming ops, consumer stalls for 3 cycles
    for (int i = 0; i < 8; i++) exp_q[i] = 16'h0111 * W'(i) + 16'h0F0F;
    idx_in = 0; idx_out = 0; cyc = 0; was_stalled = 1'b0; held = '0;
    while (idx_out < 8 && cyc < 100) begin
      in_valid  = (idx_in < 8);
      a         = 16'h0111 * W'(idx_in);
      b         = 16'h0F0F;
      sub       = 1'b0;
      out_ready = !(cyc >= 6 && cyc < 9);
      #1;
      if (was_stalled) chk("bp_stable", {16'd0, sum}, {16'd0, held});
      if (out_valid && !out_ready) begin
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        held = sum;
      end
      was_stalled = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_out%0d", idx_out), {15'd0, sum, ovfl}, {15'd0, exp_q[idx_out], 1'b0});
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", idx_out, 32'd8);

    // Reset mid-stream
    launch3();
    rst_n = 1'b0;
    #1;
    chk("mrst_outs", {15'd0, sum, out_valid}, 32'd0);
    chk("mrst_flags", {28'd0, cout, ovfl, zero, neg}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      next_cycle();
    end
    chk("mrst_drop", seen, 32'd0);
    run_vec(post, "mrst_post");

    // Flush mid-stream; op presented with flush is discarded
    launch3();
    flush = 1'b1; in_valid = 1'b1; a = 16'h0001; b = 16'h0001;
    #1;
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    next_cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      next_cycle();
    end
    chk("flush_drop", seen, 32'd0);
    run_vec(post, "flush_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined add/subtract unit built from 4-bit carry-lookahead groups.
- Operand width is split into STAGES equal segments; each segment's carry is registered into the next stage.
- Valid/ready handshake on input and output, with full backpressure.
- Produces sum, carry-out and N/Z/V flags for the execute stage; successor to the fixed 4-bit combinational CLA.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4.
- STAGES, 4, pipeline register stages; must divide WIDTH/4 (segment width SEG = WIDTH/STAGES is a multiple of 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; clears all in-flight valids.
- in_valid  in  1  operands present.
- in_ready  out  1  unit accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: A+B, 1: A-B (A + ~B + 1).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for subtract: 1 = no borrow).
- ovfl  out  1  signed overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, data/carry registers, sum, cout, ovfl, zero and neg clear to 0. in_ready reads 1 one cycle after reset deassertion at the latest.
- Transfer rules: input accepted when in_valid & in_ready. Output consumed when out_valid & out_ready.
- Operand preparation at stage 0: B' = sub ? ~b : b; carry-in = sub.
- Stage k (0..STAGES-1):
  - Adds bits [k*SEG +: SEG] of A and B' with the registered carry from stage k-1 (stage 0 uses the carry-in).
  - Uses SEG/4 CLA groups per stage; group generate/propagate gives ripple-free carry within the segment.
  - Registers the partial sum, the segment carry-out, the not-yet-processed upper operand bits, A[MSB] and B'[MSB].
- Final stage: cout = last segment carry-out. ovfl = (~A[MSB] & ~B'[MSB] & sum[MSB]) | (A[MSB] & B'[MSB] & ~sum[MSB]). zero and neg are derived from the registered final sum.
- Latency: exactly STAGES cycles from acceptance to out_valid, with no stalls. Throughput: 1 op/cycle.
- Stall: the whole pipeline holds when out_valid & ~out_ready. in_ready = ~(out_valid & ~out_ready). Bubbles are not compressed; no per-stage skid.
- Ordering: results leave strictly in acceptance order. No loss or duplication under any out_ready pattern.
- Output stability: outputs hold stable while out_valid & ~out_ready.
- flush: next edge clears every stage valid. in_ready stays high that cycle, but an input presented in the same cycle as flush is discarded. Data registers are don't-care after flush.
- Reset mid-operation: all in-flight results are dropped; no out_valid until new inputs are accepted.
- Wrap-around: unsigned results wrap modulo 2^WIDTH; overflow is reported only via ovfl/cout.

Optional Feature:
- Macro: CLA_PIPE_SAT_EN.
- Defined: when ovfl=1 the final stage replaces sum with signed saturation: 0x7FF..F if A[MSB]=0, 0x800..0 if A[MSB]=1. ovfl still reports 1; zero/neg are computed from the saturated value; cout is unchanged. No latency change.
- Undefined: sum is the raw wrapped result; no saturation logic is present.

Test Plan (WIDTH=16, STAGES=4):
- Carry chain across all segments: a=0xFFFF, b=0x0001, sub=0 -> after 4 cycles sum=0x0000, cout=1, ovfl=0, zero=1, neg=0.
- Positive overflow: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovfl=1, neg=1. With CLA_PIPE_SAT_EN: sum=0x7FFF, ovfl=1, neg=0.
- Subtract equal operands: a=0x0005, b=0x0005, sub=1 -> sum=0x0000, cout=1, zero=1. Then a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, neg=1, ovfl=0.
- Backpressure: 8 back-to-back ops, out_ready low for 3 cycles mid-stream -> in_ready low during the stall, all 8 results emitted in order with correct values, outputs stable while stalled.
- Negative overflow: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovfl=1. With CLA_PIPE_SAT_EN: sum=0x8000.
- Reset/flush mid-stream: 3 ops in flight, assert rst_n=0 (or flush=1) for 1 cycle -> out_valid=0 next cycle, all outputs 0 after reset, and the next accepted op appears exactly 4 cycles later.
